// File: rtl/dmem_block.sv
// Block-organised data memory below the direct-mapped data cache.
// Serves 128-bit line fills and write-backs with a fixed access latency.
// Optional feature macro: DMEM_ADDR_CHECK_EN adds the mem_error port and
// rejects accesses whose upper block-address bits are non-zero.
module dmem_block #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned INDEX_W = 8,
  parameter int unsigned LATENCY = 5
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [127:0]      mem_WRITE_DATA,
  output logic [127:0]      mem_READ_DATA,
  output logic              mem_busywait
`ifdef DMEM_ADDR_CHECK_EN
  ,
  output logic              mem_error
`endif
);

  localparam int unsigned Depth = 1 << INDEX_W;

  if (LATENCY < 1 || LATENCY > 255) begin : g_latency_check
    $error("dmem_block: LATENCY must be in 1..255");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 op_write_q;
  logic [INDEX_W-1:0]   idx_q;
  logic [127:0]         wdata_q;
  logic [127:0]         mem_q [Depth];
  logic                 req;
  logic                 accept;
  logic                 finish;
  logic                 line_ok;
  logic [127:0]         rd_value;

  assign req = mem_read | mem_write;

  // During reset the FSM is forced idle, so busywait simply mirrors req.
  assign mem_busywait = req & (RESET | (state_q != StDone));

`ifdef DMEM_ADDR_CHECK_EN
  logic addr_err;
  assign addr_err = |mem_address[ADDR_W-1:INDEX_W];
  assign line_ok  = ~mem_error;
  assign rd_value = line_ok ? mem_q[idx_q] : '0;

  // Range flag is decided once per access, when the request is accepted.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      mem_error <= 1'b0;
    end else if (accept) begin
      mem_error <= addr_err;
    end
  end
`else
  // Upper block-address bits are deliberately ignored: lines alias.
  logic unused_addr;
  assign unused_addr = ^mem_address[ADDR_W-1:INDEX_W];
  assign line_ok     = 1'b1;
  assign rd_value    = mem_q[idx_q];
`endif

  // Next-state logic: countdown in BUSY, abort when the cache drops req.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StBusy;
          cnt_d   = 8'(LATENCY - 1);
          accept  = 1'b1;
        end
      end
      StBusy: begin
        if (!req) begin
          state_d = StIdle;
        end else if (cnt_q == 8'd0) begin
          state_d = StDone;
          finish  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request register: later changes on the bus are ignored for this access.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
    end else if (accept) begin
      op_write_q <= mem_write;
      idx_q      <= mem_address[INDEX_W-1:0];
      wdata_q    <= mem_WRITE_DATA;
    end
  end

  // Read data only changes on a completed read; writes never touch it.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      mem_READ_DATA <= '0;
    end else if (finish && !op_write_q) begin
      mem_READ_DATA <= rd_value;
    end
  end

  // Line storage: not cleared by reset, committed only at the end of BUSY.
  always_ff @(posedge CLOCK) begin
    if (!RESET && finish && op_write_q && line_ok) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

endmodule
